// File: rtl/audio_pwm_out.sv
// ----------------------------------------------------------------------------
// audio_pwm_out
//   Audio PWM output stage fed by the ROM audio driver. PCM samples arrive
//   through a valid/ready handshake into a one-entry buffer; each sample sets
//   the duty cycle of one PWM period on pwm_out (filtered externally by RC).
//
// Parameters
//   DATA_W   sample width; one PWM period is 2**DATA_W counts
//   CLK_DIV  clocks per PWM count (>=1); period = CLK_DIV * 2**DATA_W clocks
//
// Ports
//   clk           system clock
//   rst           synchronous, active-high reset
//   en            enable playback
//   sample_in     unsigned PCM sample
//   sample_valid  sample_in is valid
//   sample_ready  buffer can accept a sample
//   sample_req    1-cycle pulse: buffer just emptied, send next sample
//   pwm_out       registered PWM output
//   underrun      1-cycle pulse: period ended with the buffer empty
//   state_dbg     current FSM state (0 IDLE, 1 RUN, 2 DRAIN) for observation
//
// Handshake: a sample transfers on a rising clk edge where sample_valid and
//   sample_ready are both high. sample_ready is combinational, never depends on
//   sample_valid, and the producer must hold sample_in stable while valid is
//   high and ready is low.
//
// Build option
//   AUDIO_PWM_UNDERRUN_MUTE_EN  defined: on underrun duty falls to mid-scale
//                               (silence). Undefined: the last sample repeats.
// ----------------------------------------------------------------------------
module audio_pwm_out #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              sample_req,
    output logic              pwm_out,
    output logic              underrun,
    output logic [1:0]        state_dbg
);

    // The prescaler needs at least one bit even when CLK_DIV is 1.
    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DATA_W-1:0] CNT_MAX   = '1;
    localparam logic [DATA_W-1:0] MID_SCALE = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] duty;
    logic [DATA_W-1:0] buf_data;
    logic              buf_full;
    logic [PRE_W-1:0]  pre_cnt;
    logic [DATA_W-1:0] pwm_cnt;

    logic tick;
    logic pend;
    logic accept;

    assign tick         = (pre_cnt == PRE_MAX);
    assign pend         = tick & (pwm_cnt == CNT_MAX);
    assign sample_ready = ~rst & en & ~buf_full & (state != DRAIN);
    assign accept       = sample_valid & sample_ready;
    assign state_dbg    = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            duty       <= '0;
            buf_data   <= '0;
            buf_full   <= 1'b0;
            pre_cnt    <= '0;
            pwm_cnt    <= '0;
            pwm_out    <= 1'b0;
            sample_req <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            sample_req <= 1'b0;
            underrun   <= 1'b0;
            case (state)
                IDLE: begin
                    pwm_out <= 1'b0;
                    pre_cnt <= '0;
                    pwm_cnt <= '0;
                    // First sample goes straight to duty so playback starts
                    // on the next edge without a buffer round-trip.
                    if (accept) begin
                        duty       <= sample_in;
                        sample_req <= 1'b1;
                        state      <= RUN;
                    end
                end
                default: begin
                    // Compare uses the count before this edge, so pwm_out
                    // trails pwm_cnt by one clock.
                    pwm_out <= (pwm_cnt < duty);
                    if (tick) begin
                        pre_cnt <= '0;
                        pwm_cnt <= pwm_cnt + 1'b1;
                    end else begin
                        pre_cnt <= pre_cnt + 1'b1;
                    end

                    if (pend) begin
                        if (state == DRAIN) begin
                            state    <= IDLE;
                            buf_full <= 1'b0;
                            pwm_out  <= 1'b0;
                        end else if (buf_full) begin
                            duty       <= buf_data;
                            buf_full   <= 1'b0;
                            sample_req <= 1'b1;
                        end else begin
                            underrun <= 1'b1;
`ifdef AUDIO_PWM_UNDERRUN_MUTE_EN
                            duty     <= MID_SCALE;
`endif
                        end
                    end

                    // A sample arriving on an empty-buffer period end lands in
                    // the buffer and waits for the following period.
                    if (accept) begin
                        buf_data <= sample_in;
                        buf_full <= 1'b1;
                    end

                    if ((state == RUN) && !en) begin
                        state <= DRAIN;
                    end
                end
            endcase
        end
    end

`ifndef AUDIO_PWM_UNDERRUN_MUTE_EN
    // Mid-scale is only used by the muting build.
    logic unused_mid;
    assign unused_mid = ^MID_SCALE;
`endif

endmodule

// File: tb/tb_audio_pwm_out.sv
// ----------------------------------------------------------------------------
// tb_audio_pwm_out
//   Bench for audio_pwm_out. Main instance: DATA_W=8, CLK_DIV=1. A second
//   instance with CLK_DIV=4 covers the prescaled period and mid-run reset.
//   The reference model describes playback as a sequence of 256-clock periods
//   whose first `duty` clocks are high, with a one-entry sample queue.
// ----------------------------------------------------------------------------
module tb_audio_pwm_out;

    localparam int P = 256;
`ifdef AUDIO_PWM_UNDERRUN_MUTE_EN
    localparam int MUTE = 1;
`else
    localparam int MUTE = 0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_PLAY  = 1;
    localparam int M_DRAIN = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, valid;
    logic [7:0] data;
    logic       sample_ready, sample_req, pwm_out, underrun;
    logic [1:0] state_dbg;

    logic       r4, e4, v4;
    logic [7:0] d4;
    logic       rdy4, req4, pwm4, und4;
    logic [1:0] st4;

    audio_pwm_out #(.DATA_W(8), .CLK_DIV(1)) dut (
        .clk(clk), .rst(rst), .en(en), .sample_in(data), .sample_valid(valid),
        .sample_ready(sample_ready), .sample_req(sample_req), .pwm_out(pwm_out),
        .underrun(underrun), .state_dbg(state_dbg)
    );

    audio_pwm_out #(.DATA_W(8), .CLK_DIV(4)) dut4 (
        .clk(clk), .rst(r4), .en(e4), .sample_in(d4), .sample_valid(v4),
        .sample_ready(rdy4), .sample_req(req4), .pwm_out(pwm4),
        .underrun(und4), .state_dbg(st4)
    );

    // ---------------- scoreboard / model state ----------------
    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] exp_q[$];
    int   m_mode = M_IDLE;
    int   m_pos  = 0;
    int   m_duty = 0;
    logic m_acc  = 1'b0;
    logic e_pwm = 1'b0, e_req = 1'b0, e_und = 1'b0;

    int cyc = 0;
    int hi_cnt = 0, req_cnt = 0, und_cnt = 0;
    int hi4 = 0;
    logic pwm4_prev = 1'b0;
    int rise4_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock of the reference: where in its period playback is, what the
    // output should be, and what happens to the queued sample at period end.
    task automatic model_step(input logic exp_rdy);
        if (rst) begin
            m_mode = M_IDLE;
            exp_q.delete();
            m_pos  = 0;
            m_duty = 0;
            m_acc  = 1'b0;
            e_pwm  = 1'b0;
            e_req  = 1'b0;
            e_und  = 1'b0;
        end else begin
            m_acc = valid && exp_rdy;
            e_req = 1'b0;
            e_und = 1'b0;
            if (m_mode == M_IDLE) begin
                e_pwm = 1'b0;
                if (m_acc) begin
                    m_duty = int'(data);
                    m_pos  = 0;
                    m_mode = M_PLAY;
                    e_req  = 1'b1;
                end
            end else begin
                e_pwm = (m_pos < m_duty);
                if (m_pos == P - 1) begin
                    m_pos = 0;
                    if (m_mode == M_DRAIN) begin
                        m_mode = M_IDLE;
                        exp_q.delete();
                        e_pwm = 1'b0;
                    end else if (exp_q.size() > 0) begin
                        m_duty = int'(exp_q.pop_front());
                        e_req  = 1'b1;
                    end else begin
                        e_und = 1'b1;
                        if (MUTE != 0) m_duty = P / 2;
                    end
                end else begin
                    m_pos++;
                end
                if (m_acc) exp_q.push_back(data);
                if (m_mode == M_PLAY && !en) m_mode = M_DRAIN;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        logic exp_rdy;
        exp_rdy = !rst && en && (exp_q.size() == 0) && (m_mode != M_DRAIN);
        #1;
        check("sample_ready", sample_ready, exp_rdy);
        @(posedge clk);
        model_step(exp_rdy);
        @(negedge clk);
        check("pwm_out", pwm_out, e_pwm);
        check("sample_req", sample_req, e_req);
        check("underrun", underrun, e_und);
        cyc++;
        if (pwm_out === 1'b1) hi_cnt++;
        if (sample_req === 1'b1) req_cnt++;
        if (underrun === 1'b1) und_cnt++;
        if (pwm4 === 1'b1) hi4++;
        if (pwm4 === 1'b1 && pwm4_prev !== 1'b1) rise4_q.push_back(cyc);
        pwm4_prev = pwm4;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [7:0] d);
        bit done;
        done  = 1'b0;
        valid = 1'b1;
        data  = d;
        for (int i = 0; i < 2000 && !done; i++) begin
            tick();
            done = m_acc;
        end
        valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        en    = 1'b1;
        valid = 1'b1;
        data  = 8'($urandom);
        run(3);
        rst   = 1'b0;
        en    = 1'b0;
        valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; en = 1'b0; valid = 1'b0; data = 8'd0;
        r4 = 1'b1; e4 = 1'b0; v4 = 1'b0; d4 = 8'd0;

        // Reset with en and valid asserted.
        do_reset();
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_pwm", pwm_out, 1'b0);

        // Normal playback 64 then 192, then an underrun period.
        en = 1'b1; req_cnt = 0; und_cnt = 0;
        send(8'd64);
        hi_cnt = 0;
        send(8'd192);
        run(255);
        check("t2_p1_high", hi_cnt, 64);
        hi_cnt = 0;
        run(255);
        check("t2_p2_high", hi_cnt, 192);
        check("t2_no_underrun", und_cnt, 0);
        check("t2_req_count", req_cnt, 2);
        run(1);
        check("t2_underrun_end", und_cnt, 1);
        hi_cnt = 0;
        run(256);
        check("t2_p3_high", hi_cnt, (MUTE != 0) ? 128 : 192);

        // Extremes.
        do_reset();
        en = 1'b1;
        send(8'd0);
        hi_cnt = 0;
        send(8'd255);
        run(255);
        check("t3_duty0_high", hi_cnt, 0);
        hi_cnt = 0;
        run(256);
        check("t3_duty255_high", hi_cnt, 255);

        // Underrun after a single sample.
        do_reset();
        en = 1'b1; und_cnt = 0;
        send(8'd64);
        hi_cnt = 0;
        run(256);
        check("t4_p1_high", hi_cnt, 64);
        check("t4_underrun", und_cnt, 1);
        hi_cnt = 0;
        run(256);
        check("t4_p2_high", hi_cnt, (MUTE != 0) ? 128 : 64);

        // Disable mid-period with a sample buffered.
        do_reset();
        en = 1'b1; req_cnt = 0;
        send(8'd64);
        hi_cnt = 0;
        send(8'd192);
        run(98);
        en = 1'b0;
        run(157);
        check("t5_drain_high", hi_cnt, 64);
        check("t5_idle_state", 32'(state_dbg), 32'd0);
        check("t5_idle_pwm", pwm_out, 1'b0);
        hi_cnt = 0;
        run(256);
        check("t5_silent", hi_cnt, 0);
        check("t5_req_count", req_cnt, 1);
        en = 1'b1;
        send(8'd10);
        hi_cnt = 0;
        run(256);
        check("t5_after_flush_high", hi_cnt, 10);

        // Randomized segments: dense/sparse feeding, en drops, rare resets.
        do_reset();
        for (int s = 0; s < 30; s++) begin
            int vmax;
            int en_mode;
            vmax    = ($urandom_range(0, 1) == 0) ? 1 : 400;
            en_mode = $urandom_range(0, 3);
            for (int c = 0; c < 600; c++) begin
                rst   = ($urandom_range(0, 4999) == 0);
                en    = (en_mode == 0) ? ($urandom_range(0, 199) != 0) : 1'b1;
                if (en_mode == 1 && c > 300 && c < 700 - 150) en = 1'b0;
                if (!valid || m_acc) data = 8'($urandom);
                valid = ($urandom_range(0, vmax) == 0);
                tick();
            end
        end

        // CLK_DIV=4 instance; main instance parked in reset meanwhile.
        rst = 1'b1; en = 1'b0; valid = 1'b0;
        r4 = 1'b1; e4 = 1'b1; v4 = 1'b1; d4 = 8'd32;
        run(2);
        #1 check("t6_rdy_in_rst", rdy4, 1'b0);
        r4 = 1'b0;
        rise4_q.delete();
        tick();
        hi4 = 0;
        tick();
        v4 = 1'b0;
        run(1023);
        check("t6_high_clocks", hi4, 128);
        run(1);
        check("t6_rise_count", rise4_q.size(), 2);
        if (rise4_q.size() >= 2) check("t6_period", rise4_q[1] - rise4_q[0], 1024);
        run(300);
        r4 = 1'b1;
        #1 check("t6_rdy_rst_mid", rdy4, 1'b0);
        tick();
        check("t6_rst_pwm", pwm4, 1'b0);
        check("t6_rst_state", 32'(st4), 32'd0);
        check("t6_rst_req", req4, 1'b0);
        check("t6_rst_und", und4, 1'b0);
        r4 = 1'b0;
        #1 check("t6_rdy_after", rdy4, 1'b1);
        hi4 = 0;
        run(20);
        check("t6_idle_silent", hi4, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
